// File: rtl/w0rm_sync_pkg.sv
// Shared constants and helpers for the ALU result return path.
// Flag bit positions inside the 4-bit ALU flag nibble.
package w0rm_sync_pkg;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    localparam int FLAG_W = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int RESULT_BEAT_W = DEFAULT_DATA_WIDTH + FLAG_W;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int beat_w(input int dw);
        return dw + FLAG_W;
    endfunction

endpackage

// File: rtl/w0rm_sync_fifo.sv
// Generic show-ahead register FIFO: head is mem[rd_ptr].
// Caller guarantees push is only asserted when there is room.
import w0rm_sync_pkg::*;

module w0rm_sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    localparam int AW = clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally left unreset; occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/w0rm_alu_result_sync.sv
// Converts the ALU's valid-only result stream into a ready/valid stream,
// throttling the ALU early enough to absorb SKID in-flight results.
import w0rm_sync_pkg::*;

module w0rm_alu_result_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SKID = 1,
    localparam int CW = clog2(DEPTH) + 1,
    localparam int BW = beat_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  result_valid,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic [3:0]            result_flags,
    output logic                  alu_ready,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [BW-1:0]         output_data,
    output logic                  overflow,
    output logic [CW-1:0]         count
);

    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 1 - SKID);

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic [BW-1:0] beat_in;
    logic          alu_ready_q, alu_ready_d;
    logic          overflow_q, overflow_d;

    assign beat_in = {result_flags[FLAG_Z], result_flags[FLAG_N],
                      result_flags[FLAG_V], result_flags[FLAG_C],
                      result};

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign pop  = !empty && output_ready;
    assign push = result_valid && (!full || pop);

    always_comb begin
        count_next  = fifo_count + CW'(push) - CW'(pop);
        alu_ready_d = (count_next <= READY_MAX);
        overflow_d  = overflow_q | (result_valid & ~push);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_ready_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            alu_ready_q <= alu_ready_d;
            overflow_q  <= overflow_d;
        end
    end

    w0rm_sync_fifo #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (beat_in),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .count (fifo_count),
        .head  (output_data)
    );

    assign output_valid = !empty;
    assign alu_ready    = alu_ready_q;
    assign overflow     = overflow_q;
    assign count        = fifo_count;

endmodule

// File: tb/tb_w0rm_alu_result_sync.sv
// Directed bench for the ALU result return-path synchronizer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_w0rm_alu_result_sync;

    logic        clk;
    logic        reset;
    logic        result_valid;
    logic [7:0]  result;
    logic [3:0]  result_flags;
    logic        alu_ready;
    logic        output_valid;
    logic        output_ready;
    logic [11:0] output_data;
    logic        overflow;
    logic [2:0]  count;

    int n_cmp;
    int n_bad;

    w0rm_alu_result_sync #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .SKID       (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .result_valid (result_valid),
        .result       (result),
        .result_flags (result_flags),
        .alu_ready    (alu_ready),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .overflow     (overflow),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d, input logic [3:0] f);
        result_valid = 1'b1;
        result       = d;
        result_flags = f;
        step();
        result_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (alu_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_alu_ready got %b want 0", alu_ready);
        end
        n_cmp++;
        if (output_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid got %b want 0", output_valid);
        end
        n_cmp++;
        if (count !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_overflow got %b want 0", overflow);
        end
        step();
        step();
        reset = 1'b0;
        step();
        n_cmp++;
        if (alu_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL release_alu_ready got %b want 1", alu_ready);
        end
        n_cmp++;
        if (output_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL release_valid got %b want 0", output_valid);
        end
    endtask

    task automatic test_single();
        output_ready = 1'b1;
        push_one(8'h5A, 4'b0100);
        n_cmp++;
        if (output_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_valid got %b want 1", output_valid);
        end
        n_cmp++;
        if (output_data !== 12'h45A) begin
            n_bad++;
            $display("FAIL single_data got %h want 45a", output_data);
        end
        step();
        n_cmp++;
        if (output_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_valid_drop got %b want 0", output_valid);
        end
        n_cmp++;
        if (count !== 3'd0) begin
            n_bad++;
            $display("FAIL single_count got %0d want 0", count);
        end
    endtask

    task automatic test_fill_backpressure();
        logic [7:0] exp_d [4];
        logic       exp_r [4];
        exp_d = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_r = '{1'b0, 1'b1, 1'b1, 1'b1};
        output_ready = 1'b0;
        push_one(8'h01, 4'h0);
        push_one(8'h02, 4'h0);
        n_cmp++;
        if (alu_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_ready2 got %b want 1", alu_ready);
        end
        push_one(8'h03, 4'h0);
        n_cmp++;
        if (alu_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_ready3 got %b want 0", alu_ready);
        end
        push_one(8'h04, 4'h0);
        n_cmp++;
        if (count !== 3'd4) begin
            n_bad++;
            $display("FAIL fill_count got %0d want 4", count);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_overflow got %b want 0", overflow);
        end
        output_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (output_valid !== 1'b1 || output_data !== {4'h0, exp_d[i]}) begin
                n_bad++;
                $display("FAIL drain_data[%0d] got v=%b %h want %h",
                         i, output_valid, output_data, {4'h0, exp_d[i]});
            end
            step();
            n_cmp++;
            if (alu_ready !== exp_r[i]) begin
                n_bad++;
                $display("FAIL drain_ready[%0d] got %b want %b",
                         i, alu_ready, exp_r[i]);
            end
        end
        n_cmp++;
        if (count !== 3'd0 || output_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty got count=%0d v=%b want 0 0",
                     count, output_valid);
        end
        output_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_d [4];
        exp_d = '{8'h21, 8'h22, 8'h23, 8'h10};
        output_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(8'h20 + 8'(i), 4'h0);
        output_ready = 1'b1;
        push_one(8'h10, 4'h0);
        n_cmp++;
        if (count !== 3'd4) begin
            n_bad++;
            $display("FAIL fullpp_count got %0d want 4", count);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL fullpp_overflow got %b want 0", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (output_valid !== 1'b1 || output_data !== {4'h0, exp_d[i]}) begin
                n_bad++;
                $display("FAIL fullpp_data[%0d] got v=%b %h want %h",
                         i, output_valid, output_data, {4'h0, exp_d[i]});
            end
            step();
        end
        output_ready = 1'b0;
    endtask

    task automatic test_overflow();
        output_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(8'h30 + 8'(i), 4'h0);
        push_one(8'hEE, 4'hF);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set got %b want 1", overflow);
        end
        n_cmp++;
        if (count !== 3'd4) begin
            n_bad++;
            $display("FAIL ovf_count got %0d want 4", count);
        end
        step();
        output_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (output_valid !== 1'b1 || output_data !== {4'h0, 8'h30 + 8'(i)}) begin
                n_bad++;
                $display("FAIL ovf_data[%0d] got v=%b %h want %h",
                         i, output_valid, output_data, {4'h0, 8'h30 + 8'(i)});
            end
            step();
        end
        n_cmp++;
        if (output_valid !== 1'b0 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_after got v=%b ovf=%b want 0 1",
                     output_valid, overflow);
        end
        output_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] q[$];
        logic [7:0]  lfsr;
        logic [11:0] pdata;
        logic        pop;
        logic        pushv;
        logic [7:0]  beat;
        logic        did_reset;
        int          cyc;
        lfsr      = 8'hA5;
        beat      = 8'd0;
        did_reset = 1'b0;
        cyc       = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_ovf_clear got %b want 0", overflow);
        end
        while ((beat < 8'd32 || q.size() > 0) && cyc < 400) begin
            cyc++;
            if (beat == 8'd20 && !did_reset) begin
                result_valid = 1'b0;
                #2 reset = 1'b1;
                #1;
                n_cmp++;
                if (count !== 3'd0 || output_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL midreset got count=%0d v=%b want 0 0",
                             count, output_valid);
                end
                q.delete();
                did_reset = 1'b1;
                step();
                reset = 1'b0;
            end
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            output_ready = (beat >= 8'd32) ? 1'b1 : lfsr[0];
            result_valid = (beat < 8'd32) && alu_ready;
            result       = beat;
            result_flags = beat[3:0];
            pop   = output_valid && output_ready;
            pdata = output_data;
            pushv = result_valid;
            step();
            if (pushv) begin
                q.push_back({beat[3:0], beat});
                beat = beat + 8'd1;
            end
            if (pop) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_stale got %h want none", pdata);
                end else if (pdata !== q[0]) begin
                    n_bad++;
                    $display("FAIL stream_data got %h want %h", pdata, q[0]);
                    void'(q.pop_front());
                end else begin
                    void'(q.pop_front());
                end
            end
        end
        result_valid = 1'b0;
        n_cmp++;
        if (cyc >= 400) begin
            n_bad++;
            $display("FAIL stream_timeout got beat=%0d left=%0d want 32 0",
                     beat, q.size());
        end
        n_cmp++;
        if (count !== 3'd0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_end got count=%0d ovf=%b want 0 0",
                     count, overflow);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        reset        = 1'b0;
        result_valid = 1'b0;
        result       = 8'h00;
        result_flags = 4'h0;
        output_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_backpressure();
        test_full_push_pop();
        test_overflow();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
